// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial datapath blocks.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-index counter width; a single-bit operand still needs one counter bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder shared by the bit-serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder that reuses one full adder LSB-first, one bit per clock,
// with valid/ready handshakes on the operand and result sides.
module bit_serial_adder
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum, fa_cout;
  logic             last_bit;

  full_adder u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so the word is aligned after WIDTH steps.
  assign sum_shift = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  assign last_bit  = (cnt == LAST);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Operand/sum shift registers, carry, bit counter and held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_shift;
          carry  <= fa_cout;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= sum_shift;
            cout <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed + randomized bench for bit_serial_adder at WIDTH=8 and WIDTH=1.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic       in_valid8 = 1'b0, in_ready8, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       out_valid8, out_ready8 = 1'b0, cout8;

  logic       in_valid1 = 1'b0, in_ready1, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, sum1;
  logic       out_valid1, out_ready1 = 1'b0, cout1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation: accept, latency, result, hold under backpressure, handshake.
  // With busy_valid set, in_valid stays high with fresh operands during the whole run.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input int hold, input logic busy_valid);
    logic [8:0] exp;
    int lat;
    int w;
    exp = 9'(ta) + 9'(tb) + 9'(tc);
    @(negedge clk);
    w = 0;
    while (!in_ready8 && w < 20) begin @(negedge clk); w++; end
    chk("in_ready8_idle", 32'(in_ready8), 32'd1);
    a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = busy_valid;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    chk("in_ready8_busy", 32'(in_ready8), 32'd0);
    lat = 0;
    while (!out_valid8 && lat < 20) begin @(negedge clk); lat++; end
    chk("latency8", 32'(lat), 32'd8);
    chk("sum8", 32'(sum8), 32'(exp[7:0]));
    chk("cout8", 32'(cout8), 32'(exp[8]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (busy_valid) begin a8 = 8'($urandom); b8 = 8'($urandom); end
      chk("hold_valid8", 32'(out_valid8), 32'd1);
      chk("hold_sum8", 32'(sum8), 32'(exp[7:0]));
      chk("hold_cout8", 32'(cout8), 32'(exp[8]));
      chk("hold_in_ready8", 32'(in_ready8), 32'd0);
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    in_valid8 = 1'b0;
    chk("post_hs_valid8", 32'(out_valid8), 32'd0);
    chk("post_hs_ready8", 32'(in_ready8), 32'd1);
  endtask

  initial begin
    int acc_prev;
    int acc_now;
    int lat;
    logic [2:0] combo;
    logic [1:0] exp1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready8", 32'(in_ready8), 32'd1);
    chk("rst_out_valid8", 32'(out_valid8), 32'd0);
    chk("rst_sum8", 32'(sum8), 32'd0);
    chk("rst_cout8", 32'(cout8), 32'd0);
    chk("rst_in_ready1", 32'(in_ready1), 32'd1);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    rst = 1'b0;

    // Directed corner cases
    op8(8'h00, 8'h00, 1'b0, 0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    op8(8'hA5, 8'h5A, 1'b1, 0, 1'b0);
    // Backpressure with new operands offered the whole time
    op8(8'h3C, 8'hC3, 1'b0, 5, 1'b1);
    op8(8'h81, 8'h7F, 1'b1, 1, 1'b0);

    // Randomized operands and backpressure lengths
    for (int k = 0; k < 12; k++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

    // Reset three cycles into RUN
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid8", 32'(out_valid8), 32'd0);
    chk("midrst_sum8", 32'(sum8), 32'd0);
    chk("midrst_in_ready8", 32'(in_ready8), 32'd1);
    @(negedge clk);
    chk("midrst_hold_valid8", 32'(out_valid8), 32'd0);
    rst = 1'b0;
    lat = 0;
    repeat (10) begin @(negedge clk); if (out_valid8) lat++; end
    chk("midrst_no_result8", 32'(lat), 32'd0);
    op8(8'h12, 8'h34, 1'b0, 0, 1'b0);

    // WIDTH=1: all combinations, back-to-back with out_ready tied high
    out_ready1 = 1'b1;
    acc_prev = -1;
    for (int i = 0; i < 8; i++) begin
      combo = 3'(i ^ 5);
      exp1 = 2'(combo[2]) + 2'(combo[1]) + 2'(combo[0]);
      @(negedge clk);
      chk("w1_in_ready", 32'(in_ready1), 32'd1);
      a1 = combo[2]; b1 = combo[1]; cin1 = combo[0]; in_valid1 = 1'b1;
      acc_now = cyc + 1;
      if (acc_prev >= 0) chk("w1_period", 32'(acc_now - acc_prev), 32'd3);
      acc_prev = acc_now;
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      chk("w1_run_valid", 32'(out_valid1), 32'd0);
      @(negedge clk);
      chk("w1_valid", 32'(out_valid1), 32'd1);
      chk("w1_sum", 32'(sum1), 32'(exp1[0]));
      chk("w1_cout", 32'(cout1), 32'(exp1[1]));
    end
    @(negedge clk);
    chk("w1_final_idle", 32'(in_ready1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
